// File: rtl/xillybus_loopback_fifo.sv
// xillybus_loopback_fifo
// Loops the xillybus host-to-FPGA 32-bit stream back to the FPGA-to-host stream
// through a single-clock FIFO. Once the host closes the write file and the
// buffer has drained, end-of-file is raised on the read stream. When both files
// are closed while draining, the buffer is flushed.
//
// Ports:
//   bus_clk, bus_rst          clock, asynchronous active-high reset
//   user_w_write_32_wren/data write strobe and data from the core
//   user_w_write_32_open      host write file open
//   user_w_write_32_full      FIFO full, back to the core
//   user_r_read_32_rden       read strobe from the core
//   user_r_read_32_open       host read file open
//   user_r_read_32_data       read data, valid the cycle after an accepted rden
//   user_r_read_32_empty      FIFO empty, to the core
//   user_r_read_32_eof        end-of-file, to the core
//   fill_level                words stored, 0..2**DEPTH_LOG2
//   overflow / underflow      sticky error flags, cleared only by bus_rst
module xillybus_loopback_fifo #(
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst,
    input  logic                  user_w_write_32_wren,
    input  logic [DW-1:0]         user_w_write_32_data,
    input  logic                  user_w_write_32_open,
    output logic                  user_w_write_32_full,
    input  logic                  user_r_read_32_rden,
    input  logic                  user_r_read_32_open,
    output logic [DW-1:0]         user_r_read_32_data,
    output logic                  user_r_read_32_empty,
    output logic                  user_r_read_32_eof,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   flush;

    logic [DW-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    fill_q;
    logic [DEPTH_LOG2:0]    fill_next;
    logic                   full_q;
    logic                   empty_q;
    logic                   ovf_q;
    logic                   unf_q;
    logic [DW-1:0]          rdata_q;
    logic                   wr_acc;
    logic                   rd_acc;

    assign wr_acc = user_w_write_32_wren && !full_q;
    assign rd_acc = user_r_read_32_rden && !empty_q;

    always_comb begin
        fill_next = fill_q;
        case ({wr_acc, rd_acc})
            2'b10:   fill_next = fill_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   fill_next = fill_q - (DEPTH_LOG2 + 1)'(1);
            default: fill_next = fill_q;
        endcase
    end

    // EOF state machine
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        flush      = 1'b0;
        case (state)
            S_IDLE: begin
                if (user_w_write_32_open) state_next = S_FILL;
            end
            S_FILL: begin
                if (!user_w_write_32_open) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (user_w_write_32_open) begin
                    state_next = S_FILL;
                end else if (!user_r_read_32_open) begin
                    state_next = S_IDLE;
                    flush      = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge bus_clk) begin
        if (wr_acc) mem[wr_ptr] <= user_w_write_32_data;
    end

    // Flush takes priority over any access in the same cycle; full/empty are
    // registered from the next fill level so they line up with fill_level.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (rd_acc) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            fill_q  <= fill_next;
            full_q  <= (fill_next == FULL_LVL);
            empty_q <= (fill_next == '0);
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (user_w_write_32_wren && full_q)  ovf_q <= 1'b1;
            if (user_r_read_32_rden && empty_q)  unf_q <= 1'b1;
        end
    end

    assign user_w_write_32_full = full_q;
    assign user_r_read_32_empty = empty_q;
    assign user_r_read_32_data  = rdata_q;
    assign user_r_read_32_eof   = (state == S_DRAIN) && empty_q;
    assign fill_level           = fill_q;
    assign overflow             = ovf_q;
    assign underflow            = unf_q;

endmodule

// File: tb/tb_xillybus_loopback_fifo.sv
// Directed bench for xillybus_loopback_fifo with a 16-word FIFO.
module tb_xillybus_loopback_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned DL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wren;
    logic [DW-1:0] wdata;
    logic          wopen;
    logic          full;
    logic          rden;
    logic          ropen;
    logic [DW-1:0] rdata;
    logic          empty;
    logic          eof;
    logic [DL:0]   fill;
    logic          ovf;
    logic          unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xillybus_loopback_fifo #(
        .DW(DW),
        .DEPTH_LOG2(DL)
    ) dut (
        .bus_clk              (clk),
        .bus_rst              (rst),
        .user_w_write_32_wren (wren),
        .user_w_write_32_data (wdata),
        .user_w_write_32_open (wopen),
        .user_w_write_32_full (full),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_open  (ropen),
        .user_r_read_32_data  (rdata),
        .user_r_read_32_empty (empty),
        .user_r_read_32_eof   (eof),
        .fill_level           (fill),
        .overflow             (ovf),
        .underflow            (unf)
    );

    typedef struct {
        logic        wren;
        logic [31:0] wdata;
        logic        rden;
        logic        wo;
        logic        ro;
        logic        e_full;
        logic        e_empty;
        logic        e_eof;
        int          e_fill;
        logic [31:0] e_data;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_and_check(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, " empty"}, 32'(empty), 1);
        chk({tag, " full"},  32'(full),  0);
        chk({tag, " fill"},  32'(fill),  0);
        chk({tag, " eof"},   32'(eof),   0);
        chk({tag, " data"},  rdata,      0);
        chk({tag, " ovf"},   32'(ovf),   0);
        chk({tag, " unf"},   32'(unf),   0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // EOF sequence: 4 writes, close write file, read 4, then reopen/close.
        tbl[0]  = '{1'b1, 32'h500, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h499, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 32'h501, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'h499, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 32'h502, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 32'h499, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 32'h503, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 32'h499, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 32'h499, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 32'h500, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'h501, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h502, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h503, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h503, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h503, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h503, 1'b1, 1'b1};

        rst = 1'b1; wren = 1'b0; wdata = '0; rden = 1'b0; wopen = 1'b0; ropen = 1'b0;
        tick(); tick();
        chk("rst empty", 32'(empty), 1);
        chk("rst full",  32'(full),  0);
        chk("rst fill",  32'(fill),  0);
        chk("rst eof",   32'(eof),   0);
        chk("rst data",  rdata,      0);
        chk("rst ovf",   32'(ovf),   0);
        chk("rst unf",   32'(unf),   0);
        rst = 1'b0;
        wopen = 1'b1; ropen = 1'b1;
        tick();

        // T1: reset in the middle of traffic
        for (int i = 0; i < 5; i++) begin
            wren = 1'b1; wdata = 32'h100 + i;
            tick();
        end
        wren = 1'b0;
        chk("t1 fill before rst", 32'(fill), 5);
        pulse_reset_and_check("t1");
        tick();

        // T2: basic loopback
        for (int i = 0; i < 10; i++) begin
            wren = 1'b1; wdata = i;
            tick();
        end
        wren = 1'b0;
        chk("t2 fill", 32'(fill), 10);
        for (int i = 0; i < 10; i++) begin
            rden = 1'b1;
            tick();
            chk($sformatf("t2 data[%0d]", i), rdata, i);
            chk($sformatf("t2 eof[%0d]", i), 32'(eof), 0);
        end
        rden = 1'b0;
        chk("t2 empty", 32'(empty), 1);
        chk("t2 unf", 32'(unf), 0);

        // T3: full, overflow and pointer wrap
        for (int i = 0; i < 16; i++) begin
            wren = 1'b1; wdata = 32'h300 + i;
            tick();
        end
        chk("t3 full", 32'(full), 1);
        chk("t3 fill16", 32'(fill), 16);
        chk("t3 empty0", 32'(empty), 0);
        chk("t3 ovf before", 32'(ovf), 0);
        wdata = 32'hDEAD;
        tick();
        wren = 1'b0;
        chk("t3 ovf", 32'(ovf), 1);
        chk("t3 fill after drop", 32'(fill), 16);
        for (int i = 0; i < 8; i++) begin
            rden = 1'b1;
            tick();
            chk($sformatf("t3 rd1[%0d]", i), rdata, 32'h300 + i);
        end
        rden = 1'b0;
        chk("t3 fill8", 32'(fill), 8);
        chk("t3 full0", 32'(full), 0);
        for (int i = 0; i < 8; i++) begin
            wren = 1'b1; wdata = 32'h310 + i;
            tick();
        end
        wren = 1'b0;
        chk("t3 refull", 32'(full), 1);
        for (int i = 0; i < 16; i++) begin
            rden = 1'b1;
            tick();
            chk($sformatf("t3 rd2[%0d]", i), rdata, (i < 8) ? 32'h308 + i : 32'h310 + i - 8);
        end
        rden = 1'b0;
        chk("t3 empty", 32'(empty), 1);
        chk("t3 full end", 32'(full), 0);

        // T4: simultaneous read and write
        for (int i = 0; i < 3; i++) begin
            wren = 1'b1; wdata = 32'h400 + i;
            tick();
        end
        chk("t4 fill3", 32'(fill), 3);
        for (int i = 0; i < 20; i++) begin
            wren = 1'b1; wdata = 32'h410 + i; rden = 1'b1;
            tick();
            chk($sformatf("t4 data[%0d]", i), rdata, (i < 3) ? 32'h400 + i : 32'h410 + i - 3);
            chk($sformatf("t4 fill[%0d]", i), 32'(fill), 3);
        end
        wren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4 drain[%0d]", i), rdata, 32'h421 + i);
        end
        rden = 1'b0;
        chk("t4 empty", 32'(empty), 1);
        chk("t4 unf before", 32'(unf), 0);
        wren = 1'b1; wdata = 32'h499; rden = 1'b1;
        tick();
        wren = 1'b0; rden = 1'b0;
        chk("t4 fill1", 32'(fill), 1);
        chk("t4 unf", 32'(unf), 1);
        chk("t4 data held", rdata, 32'h423);
        chk("t4 empty0", 32'(empty), 0);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("t4 data 499", rdata, 32'h499);
        chk("t4 empty again", 32'(empty), 1);

        // T5: EOF sequencing (table-driven)
        for (int i = 0; i < 12; i++) begin
            wren = tbl[i].wren; wdata = tbl[i].wdata; rden = tbl[i].rden;
            wopen = tbl[i].wo; ropen = tbl[i].ro;
            tick();
            chk($sformatf("t5[%0d] full", i),  32'(full),  32'(tbl[i].e_full));
            chk($sformatf("t5[%0d] empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("t5[%0d] eof", i),   32'(eof),   32'(tbl[i].e_eof));
            chk($sformatf("t5[%0d] fill", i),  32'(fill),  32'(tbl[i].e_fill));
            chk($sformatf("t5[%0d] data", i),  rdata,      tbl[i].e_data);
            chk($sformatf("t5[%0d] ovf", i),   32'(ovf),   32'(tbl[i].e_ovf));
            chk($sformatf("t5[%0d] unf", i),   32'(unf),   32'(tbl[i].e_unf));
        end
        wren = 1'b0; rden = 1'b0;

        // Sticky flags clear only on reset
        pulse_reset_and_check("rst2");
        wopen = 1'b1; ropen = 1'b1;
        tick();

        // T6: flush when both files close while draining
        for (int i = 0; i < 6; i++) begin
            wren = 1'b1; wdata = 32'h600 + i;
            tick();
        end
        wren = 1'b0;
        wopen = 1'b0;
        tick();
        chk("t6 fill6", 32'(fill), 6);
        chk("t6 eof draining", 32'(eof), 0);
        ropen = 1'b0;
        tick();
        chk("t6 fill flushed", 32'(fill), 0);
        chk("t6 empty", 32'(empty), 1);
        chk("t6 eof idle", 32'(eof), 0);
        chk("t6 full", 32'(full), 0);
        chk("t6 unf before", 32'(unf), 0);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("t6 unf", 32'(unf), 1);
        chk("t6 data", rdata, 0);
        chk("t6 ovf", 32'(ovf), 0);
        chk("t6 fill after rden", 32'(fill), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
